// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC frame accumulator.
package mac_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_e;

    localparam int unsigned IN_W_DEF      = 16;
    localparam int unsigned ACC_W_DEF     = 24;
    localparam int unsigned FRAME_LEN_DEF = 4;

endpackage

// File: rtl/mac_frame_accumulator_sat_adder.sv
// Unsigned W-bit adder that clamps to all-ones when the true sum does not fit.
module sat_adder #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] raw_sum;

    // Add with one guard bit; a carry out means the result must saturate.
    always_comb begin
        raw_sum = {1'b0, a_i} + {1'b0, b_i};
        ovf_o   = raw_sum[W];
        sum_o   = raw_sum[W] ? '1 : raw_sum[W-1:0];
    end

endmodule

// File: rtl/mac_frame_accumulator.sv
// Sums FRAME_LEN consecutive upstream MAC results and presents the saturated
// frame sum through a valid/ready handshake; one frame in flight at a time.
module mac_frame_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned IN_W      = IN_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  d_i,
    input  logic             d_valid_i,
    output logic             d_ready_o,
    input  logic             clear_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             ovf_o
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_ovf_q, frame_ovf_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q, sum_valid_d;

    logic [ACC_W-1:0] d_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             ready;
    logic             accept;
    logic             last_sample;
    logic             sum_taken;

    assign d_ext = ACC_W'(d_i);

    sat_adder #(
        .W (ACC_W)
    ) u_sat_adder (
        .a_i   (acc_q),
        .b_i   (d_ext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // State register; reset and abort both return to accumulating.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (rst_i) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: finish a frame into HOLD, release HOLD on handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        if (clear_i) begin
            state_d = ACC;
        end else begin
            unique case (state_q)
                ACC:  if (last_sample) state_d = HOLD;
                HOLD: if (sum_taken)   state_d = ACC;
                default: state_d = ACC;
            endcase
        end
    end

    // Output logic: samples are only taken while accumulating and not aborting.
    always_comb begin
        ready       = (state_q == ACC) && !clear_i && !rst_i;
        accept      = d_valid_i && ready;
        last_sample = accept && (cnt_q == LAST_CNT);
        sum_taken   = sum_valid_q && sum_ready_i;
    end

    // Datapath next values: accumulate, close out a frame, or drop on abort.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        frame_ovf_d = frame_ovf_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        sum_valid_d = sum_valid_q;
        if (clear_i) begin
            acc_d       = '0;
            cnt_d       = '0;
            frame_ovf_d = 1'b0;
            ovf_d       = 1'b0;
            sum_valid_d = 1'b0;
        end else if (last_sample) begin
            sum_d       = add_sum;
            ovf_d       = frame_ovf_q | add_ovf;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            frame_ovf_d = 1'b0;
        end else if (accept) begin
            acc_d       = add_sum;
            cnt_d       = cnt_q + 1'b1;
            frame_ovf_d = frame_ovf_q | add_ovf;
        end else if (sum_taken) begin
            sum_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end
    end

    // Datapath registers, all cleared by reset including the presented sum.
    always_ff @(posedge clk_i) begin
        // NOTE: every register here has a reset value; there is no storage
        // array that would make resetting it costly.
        if (rst_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            frame_ovf_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            frame_ovf_q <= frame_ovf_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign d_ready_o   = ready;
    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Scoreboard bench: two accumulators (24-bit and 17-bit sums) share one input
// stream; a frame-level reference model predicts sums, handshakes and flow.
module tb_mac_frame_accumulator;

    localparam int FRAME_LEN = 4;

    typedef struct {
        longint unsigned sum;
        bit              ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] d_i = '0;
    logic        d_valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        sum_ready_i = 1'b0;

    logic        d_ready_24, sum_valid_24, ovf_24;
    logic [23:0] sum_24;
    logic        d_ready_17, sum_valid_17, ovf_17;
    logic [16:0] sum_17;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit              hold = 1'b0;
    longint unsigned frame_total = 0;
    int              n_samp = 0;
    longint unsigned shadow_24 = 0, shadow_17 = 0;
    bit              exp_ovf_24 = 1'b0, exp_ovf_17 = 1'b0;
    exp_t            q24[$];
    exp_t            q17[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    mac_frame_accumulator #(.IN_W(16), .ACC_W(24), .FRAME_LEN(FRAME_LEN)) u_dut24 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .d_i         (d_i),
        .d_valid_i   (d_valid_i),
        .d_ready_o   (d_ready_24),
        .clear_i     (clear_i),
        .sum_o       (sum_24),
        .sum_valid_o (sum_valid_24),
        .sum_ready_i (sum_ready_i),
        .ovf_o       (ovf_24)
    );

    mac_frame_accumulator #(.IN_W(16), .ACC_W(17), .FRAME_LEN(FRAME_LEN)) u_dut17 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .d_i         (d_i),
        .d_valid_i   (d_valid_i),
        .d_ready_o   (d_ready_17),
        .clear_i     (clear_i),
        .sum_o       (sum_17),
        .sum_valid_o (sum_valid_17),
        .sum_ready_i (sum_ready_i),
        .ovf_o       (ovf_17)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Saturated sum of a frame: clamp the plain total to the sum width.
    function automatic exp_t predict(input longint unsigned total, input int w);
        exp_t            e;
        longint unsigned max_v = (64'd1 << w) - 64'd1;
        e.ovf = (total > max_v);
        e.sum = e.ovf ? max_v : total;
        return e;
    endfunction

    // Reference model: frame bookkeeping driven by the bench's own inputs.
    always @(posedge clk) begin
        exp_t e;
        if (rst_i) begin
            hold = 1'b0; frame_total = 0; n_samp = 0;
            q24.delete(); q17.delete();
            shadow_24 = 0; shadow_17 = 0;
        end else if (clear_i) begin
            if (hold) begin
                if (q24.size() > 0) void'(q24.pop_back());
                if (q17.size() > 0) void'(q17.pop_back());
            end
            hold = 1'b0; frame_total = 0; n_samp = 0;
        end else if (hold) begin
            if (sum_ready_i) hold = 1'b0;
        end else if (d_valid_i) begin
            frame_total += longint'(d_i);
            n_samp++;
            if (n_samp == FRAME_LEN) begin
                e = predict(frame_total, 24); q24.push_back(e);
                shadow_24 = e.sum; exp_ovf_24 = e.ovf;
                e = predict(frame_total, 17); q17.push_back(e);
                shadow_17 = e.sum; exp_ovf_17 = e.ovf;
                hold = 1'b1; frame_total = 0; n_samp = 0;
            end
        end
    end

    // Per-cycle flow checks: ready, valid timing, held outputs.
    always @(negedge clk) begin
        bit exp_rdy;
        if (chk_en) begin
            exp_rdy = !hold && !clear_i && !rst_i;
            check("d_ready_24", d_ready_24, exp_rdy);
            check("d_ready_17", d_ready_17, exp_rdy);
            check("sum_valid_24", sum_valid_24, hold);
            check("sum_valid_17", sum_valid_17, hold);
            check("sum_o_hold_24", sum_24, shadow_24);
            check("sum_o_hold_17", sum_17, shadow_17);
            check("ovf_o_24", ovf_24, hold ? exp_ovf_24 : 1'b0);
            check("ovf_o_17", ovf_17, hold ? exp_ovf_17 : 1'b0);
        end
    end

    // Monitor: pop and compare whenever a sum is handed over downstream.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en && sum_ready_i && !clear_i && !rst_i) begin
            if (sum_valid_24) begin
                if (q24.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_24: got sum 0x%0h expected no sum", sum_24);
                end else begin
                    e = q24.pop_front();
                    check("sb_sum_24", sum_24, e.sum);
                    check("sb_ovf_24", ovf_24, e.ovf);
                end
            end
            if (sum_valid_17) begin
                if (q17.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_17: got sum 0x%0h expected no sum", sum_17);
                end else begin
                    e = q17.pop_front();
                    check("sb_sum_17", sum_17, e.sum);
                    check("sb_ovf_17", ovf_17, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the accumulator takes it.
    task automatic send(input logic [15:0] d);
        bit ok = 1'b0;
        d_valid_i = 1'b1;
        d_i       = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ok = d_ready_24;
            tick();
            if (ok) break;
        end
        d_valid_i = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept expected accept of 0x%0h", d);
        end
    endtask

    initial begin
        int t0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_i = 1'b0;
        sum_ready_i = 1'b1;
        tick();

        // basic frame of MAC results
        send(16'd0); send(16'd5); send(16'd26); send(16'd65);
        tick(); tick();

        // saturation on the 17-bit instance, then a clean frame
        repeat (4) send(16'hFFFF);
        repeat (4) send(16'd1);
        tick(); tick();

        // backpressure with upstream still offering data
        sum_ready_i = 1'b0;
        send(16'd100); send(16'd200); send(16'd300); send(16'd400);
        d_valid_i = 1'b1; d_i = 16'd7;
        repeat (5) tick();
        sum_ready_i = 1'b1;
        t0 = cyc_cnt;
        send(16'd7);
        check("bp_release_cycles", longint'(cyc_cnt - t0), 64'd2);
        send(16'd8); send(16'd9); send(16'd10);
        tick(); tick();

        // abort mid-frame with a competing valid sample
        send(16'd10); send(16'd20);
        clear_i = 1'b1; d_valid_i = 1'b1; d_i = 16'd99;
        tick();
        clear_i = 1'b0; d_valid_i = 1'b0;
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        tick(); tick();

        // abort while a sum is pending
        sum_ready_i = 1'b0;
        repeat (4) send(16'd5);
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0; sum_ready_i = 1'b1;
        tick(); tick();

        // reset mid-frame, then in HOLD
        send(16'd3); send(16'd4);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        repeat (4) send(16'd9);
        tick(); tick();
        sum_ready_i = 1'b0;
        repeat (4) send(16'd11);
        tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        sum_ready_i = 1'b1;
        send(16'd1); send(16'd2); send(16'd4); send(16'd8);
        tick(); tick();

        // continuous stream: one bubble between frames
        t0 = cyc_cnt;
        repeat (12) send(16'd1);
        check("stream_cycles", longint'(cyc_cnt - t0), 64'd14);
        tick(); tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            d_valid_i   = ($urandom % 4) != 0;
            d_i         = (($urandom % 4) == 0) ? 16'hFFFF : 16'($urandom);
            sum_ready_i = ($urandom % 4) != 0;
            clear_i     = ($urandom % 40) == 0;
            rst_i       = ($urandom % 120) == 0;
            tick();
        end

        // drain
        d_valid_i = 1'b0; clear_i = 1'b0; rst_i = 1'b0; sum_ready_i = 1'b1;
        repeat (4) tick();
        check("sb_drain_24", q24.size(), 64'd0);
        check("sb_drain_17", q17.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
